// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state encoding and default parameters for mem_responder.
package mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam int BITS_DEF        = 32;
   localparam int ADDR_BITS_DEF   = 9;
   localparam int WAIT_STATES_DEF = 2;
   localparam int CNT_BITS        = 4;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port storage with synchronous write and registered read, no reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int BITS      = BITS_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [BITS-1:0]      wdata,
   output logic [BITS-1:0]      rdata
);
   logic [BITS-1:0] mem [2**ADDR_BITS];
   logic [BITS-1:0] rdata_q;
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata_q <= mem[addr];
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder (IDLE/WAIT/RESP) in front of mem_array.
// Define MEM_BOUNDS_CHECK_EN to reject addresses with bits set above ADDR_BITS (Err pulse).
module mem_responder
   import mem_pkg::*;
#(
   parameter int BITS        = BITS_DEF,
   parameter int ADDR_BITS   = ADDR_BITS_DEF,
   parameter int WAIT_STATES = WAIT_STATES_DEF
) (
   input  logic            Clock,
   input  logic            reset,
   input  logic [BITS-1:0] MARVal,
   input  logic            Read,
   input  logic            Write,
   input  logic [BITS-1:0] MDRVal,
   output logic [BITS-1:0] Mdatain,
   output logic            Ready,
   output logic            Busy,
   output logic            Err
);
   state_t state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [BITS-1:0] addr_q, addr_d, data_q, data_d, mdatain_q, mdatain_d;
   logic [BITS-1:0] addr_src, rdata;
   logic rd_q, rd_d, ready_q, ready_d, busy_q, busy_d, err_q, err_d;
   logic we, oob_in, oob_cur;
   // The array samples its address on the edge entering RESP; with no wait states that is the accept edge.
   assign addr_src = (state_q == IDLE) ? MARVal : addr_q;
`ifdef MEM_BOUNDS_CHECK_EN
   assign oob_in  = |addr_src[BITS-1:ADDR_BITS];
   assign oob_cur = |addr_q[BITS-1:ADDR_BITS];
`else
   logic unused_hi;
   assign unused_hi = ^addr_src[BITS-1:ADDR_BITS];
   assign oob_in    = 1'b0;
   assign oob_cur   = 1'b0;
`endif
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      data_d    = data_q;
      rd_d      = rd_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      busy_d    = busy_q;
      mdatain_d = (ready_q && rd_q) ? (oob_cur ? '0 : rdata) : mdatain_q;
      we        = ready_q && !rd_q && !oob_cur && reset;
      case (state_q)
         IDLE: if (Read || Write) begin
            addr_d  = MARVal;
            data_d  = MDRVal;
            rd_d    = Read;
            busy_d  = 1'b1;
            cnt_d   = CNT_BITS'(WAIT_STATES);
            state_d = (WAIT_STATES == 0) ? RESP : WAIT;
            ready_d = (WAIT_STATES == 0);
            err_d   = (WAIT_STATES == 0) && oob_in;
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == 1) begin
               state_d = RESP;
               ready_d = 1'b1;
               err_d   = oob_in;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end
   always_ff @(posedge Clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         rd_q      <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         mdatain_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         rd_q      <= rd_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         mdatain_q <= mdatain_d;
      end
   end
   mem_array #(.BITS(BITS), .ADDR_BITS(ADDR_BITS)) u_array (
      .clk   (Clock),
      .we    (we),
      .addr  (addr_src[ADDR_BITS-1:0]),
      .wdata (data_q),
      .rdata (rdata)
   );
   assign Mdatain = mdatain_d;
   assign Ready   = ready_q;
   assign Busy    = busy_q;
   assign Err     = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (2 and 0 wait states) on shared stimulus, each against a request-level model.
module tb_mem_responder;
   logic clk = 0, rst_n = 0, rd = 0, wr = 0;
   logic [31:0] mar = 0, mdr = 0;
   logic [31:0] md [2];
   logic rdy [2], bsy [2], er [2];
   bit armed = 0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit oob(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
      return a[31:9] != 0;
`else
      return a[31] & 1'b0;
`endif
   endfunction

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int WS = (g == 0) ? 2 : 0;
      mem_responder #(.BITS(32), .ADDR_BITS(9), .WAIT_STATES(WS)) dut (
         .Clock(clk), .reset(rst_n), .MARVal(mar), .Read(rd), .Write(wr), .MDRVal(mdr),
         .Mdatain(md[g]), .Ready(rdy[g]), .Busy(bsy[g]), .Err(er[g]));
      logic [31:0] mm [512];
      bit kn [512];
      int left = 0;
      bit op_rd = 0, md_kn = 1;
      logic [31:0] a_l = 0, d_l = 0, exp_md = 0;
      // left = cycles of the request still to run; the last one is the Ready cycle
      always @(posedge clk) begin
         if (!rst_n) begin
            left = 0;
            exp_md = 0;
            md_kn = 1;
         end else if (left == 0) begin
            if (rd || wr) begin
               left = WS + 1;
               op_rd = rd;
               a_l = mar;
               d_l = mdr;
            end
         end else begin
            left--;
            if (left == 0 && !op_rd && !oob(a_l)) begin
               mm[a_l[8:0]] = d_l;
               kn[a_l[8:0]] = 1;
            end
         end
         if (rst_n && left == 1 && op_rd) begin
            md_kn = oob(a_l) || kn[a_l[8:0]];
            exp_md = oob(a_l) ? 32'h0 : mm[a_l[8:0]];
         end
      end
      always @(negedge clk) if (armed) begin
         chk($sformatf("busy%0d", g), 32'(bsy[g]), 32'(left > 0));
         chk($sformatf("ready%0d", g), 32'(rdy[g]), 32'(left == 1));
         chk($sformatf("err%0d", g), 32'(er[g]), 32'(left == 1 && oob(a_l)));
         if (md_kn) chk($sformatf("mdatain%0d", g), md[g], exp_md);
      end
   end

   int l0, l1;
   logic [31:0] v0, v1;
   logic e0, e1;

   task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      int k;
      l0 = 0; l1 = 0; v0 = 0; v1 = 0; e0 = 0; e1 = 0;
      for (k = 0; k < 50 && (bsy[0] || bsy[1]); k++) @(negedge clk);
      if (k == 50) chk("idle_timeout", 32'(1), 32'(0));
      rd = r; wr = w; mar = a; mdr = d;
      @(negedge clk);
      rd = 0; wr = 0; mar = $urandom; mdr = $urandom;
      for (int i = 1; i <= 6; i++) begin
         if (rdy[0] && l0 == 0) begin l0 = i; v0 = md[0]; e0 = er[0]; end
         if (rdy[1] && l1 == 0) begin l1 = i; v1 = md[1]; e1 = er[1]; end
         if (i < 6) @(negedge clk);
      end
   endtask

   initial begin
      int n;
      bit prev;
      repeat (2) @(negedge clk);
      armed = 1;
      chk("rst_mdatain", md[0], 32'h0);
      chk("rst_ready", 32'(rdy[0]), 32'h0);
      chk("rst_busy", 32'(bsy[1]), 32'h0);
      rst_n = 1;
      @(negedge clk);
      req(0, 1, 32'h05, 32'h22);
      chk("lat_ws2", 32'(l0), 32'd3);
      chk("lat_ws0", 32'(l1), 32'd1);
      req(1, 0, 32'h05, 32'h0);
      chk("rd05_ws2", v0, 32'h22);
      chk("rd05_ws0", v1, 32'h22);
      req(1, 1, 32'h05, 32'h99);
      chk("rdwins", v0, 32'h22);
      req(1, 0, 32'h05, 32'h0);
      chk("wr_dropped", v0, 32'h22);
      req(0, 1, 32'h10, 32'hDEADBEEF);
      req(1, 0, 32'h10, 32'h0);
      chk("ws0_lat_raw", 32'(l1), 32'd1);
      chk("ws0_raw", v1, 32'hDEADBEEF);
      req(0, 1, 32'h07, 32'h11);
      wr = 1; mar = 32'h07; mdr = 32'h55;
      @(negedge clk);
      wr = 0; rst_n = 0; n = 0;
      if (rdy[0]) n++;
      @(negedge clk);
      rst_n = 1;
      repeat (4) begin if (rdy[0]) n++; @(negedge clk); end
      chk("abort_no_ready", 32'(n), 32'h0);
      req(1, 0, 32'h07, 32'h0);
      chk("abort_ws2", v0, 32'h11);
      chk("abort_ws0", v1, 32'h11);
      req(0, 1, 32'h205, 32'h77);
      req(1, 0, 32'h205, 32'h0);
`ifdef MEM_BOUNDS_CHECK_EN
      chk("oob_data", v0, 32'h0);
      chk("oob_err", 32'(e0), 32'h1);
      req(1, 0, 32'h05, 32'h0);
      chk("oob_nowrite", v0, 32'h22);
`else
      chk("wrap_data", v0, 32'h77);
      chk("wrap_err", 32'(e0), 32'h0);
      req(1, 0, 32'h05, 32'h0);
      chk("wrap_alias", v0, 32'h77);
`endif
      rd = 1; mar = 32'h10; n = 0; prev = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) rd = 0;
         if (prev) chk("busy_after_ready", 32'(bsy[0]), 32'h0);
         prev = rdy[0];
         if (rdy[0]) n++;
         @(negedge clk);
      end
      chk("one_ready", 32'(n), 32'h1);
      for (int i = 0; i < 3000; i++) begin
         rd = ($urandom % 4) == 0;
         wr = ($urandom % 4) == 0;
         mar = (($urandom % 8) == 0 ? 32'h200 : 32'h0) | ($urandom % 16);
         mdr = $urandom;
         rst_n = ($urandom % 100) != 0;
         @(negedge clk);
      end
      rd = 0; wr = 0; rst_n = 1;
      repeat (6) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter BITS, default 32, data and address word width.
REQ-002 SHALL have parameter ADDR_BITS, default 9, implemented address width (512 words).
REQ-003 SHALL have parameter WAIT_STATES, default 2, extra cycles between request and response (0..15).
REQ-004 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port MARVal  input  BITS  word address from the datapath MAR.
REQ-007 SHALL have port Read  input  1  read request, sampled in IDLE.
REQ-008 SHALL have port Write  input  1  write request, sampled in IDLE.
REQ-009 SHALL have port MDRVal  input  BITS  write data from the datapath MDR.
REQ-010 SHALL have port Mdatain  output  BITS  read data toward the MDR, registered.
REQ-011 SHALL have port Ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port Busy  output  1  high while a request is in flight.
REQ-013 SHALL have port Err  output  1  out-of-range access pulse, coincident with Ready.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: on (Read|Write)=1, SHALL latch address, data and op; go to WAIT with counter=WAIT_STATES, or directly to RESP if WAIT_STATES=0.
REQ-016 WAIT: SHALL decrement counter each cycle; go to RESP on the cycle the counter reaches 1.
REQ-017 RESP: SHALL perform the access, assert Ready for exactly one cycle, return to IDLE.
REQ-018 Latency: Ready SHALL be high in cycle WAIT_STATES+1 after the sampling edge.
REQ-019 Read: Mdatain SHALL update with mem[addr] in the same cycle Ready is high; it holds until the next read completes.
REQ-020 Write: mem[addr] SHALL update at the end of the RESP cycle; Mdatain unchanged.
REQ-021 Read=Write=1 together: read SHALL win; write dropped.
REQ-022 Busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-023 Requests arriving while Busy=1 SHALL be ignored, not queued.
REQ-024 Inputs SHALL be sampled only at the IDLE acceptance edge; later changes have no effect.
REQ-025 A request accepted in the cycle after RESP (back-to-back) SHALL be served normally.
REQ-026 Read-after-write to the same address SHALL return the newly written value.

Reset
REQ-027 reset=0 at an edge SHALL force IDLE, Mdatain=0, Ready=0, Busy=0, Err=0, counter=0.
REQ-028 reset mid-operation SHALL abort the request; a pending write SHALL NOT reach the array.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro MEM_BOUNDS_CHECK_EN defined: address bits above ADDR_BITS nonzero -> no array access, read returns 0, write dropped, Err=1 with Ready.
REQ-031 Macro undefined: upper address bits SHALL be ignored (wrap modulo 2^ADDR_BITS), Err tied 0; port list unchanged.

Structure
REQ-032 Shared package mem_pkg SHALL hold the state encoding (IDLE/WAIT/RESP) and default parameter constants.
REQ-033 Storage SHALL be sub-module mem_array: single port, synchronous write, registered read, no reset.

Verification
REQ-034 Reset, then Write MARVal=0x05 MDRVal=0x22 -> Ready pulse 3 cycles later; then Read 0x05 -> Mdatain=0x22 with Ready.
REQ-035 WAIT_STATES=0: Read 0x10 after writing 0xDEADBEEF -> Ready and Mdatain=0xDEADBEEF on the next cycle.
REQ-036 Read=Write=1, MARVal=0x05, MDRVal=0x99 -> Mdatain=0x22, mem[0x05] stays 0x22.
REQ-037 Write 0x07/0x55, reset low one cycle during WAIT -> no Ready; a later read of 0x07 returns the prior value.
REQ-038 MARVal=0x205: with MEM_BOUNDS_CHECK_EN -> Err=1, Mdatain=0; without -> accesses 0x005, Err=0.
REQ-039 Read asserted again during Busy -> exactly one Ready; Busy low the cycle after Ready.
